spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI mode-0 master (CPOL=0, CPHA=0, MSB first) on the system clock domain.
//  Frames one or more bytes under one active-low chip select and shifts MOSI out and MISO in.
//  Pairs with the team's oversampling SPI slave, so SCK half-periods are long enough for 3-flop edge sync.
//  Host side: byte valid/ready in, byte valid pulse out.
// PARAMETERS
//  HALF_DIV   8   clk cycles per SCK half-period; legal range 8..255.
//  SETUP_CYC  6   clk cycles from cs low to the first SCK rise, and from the last SCK fall to cs high; min 4.
//  GAP_CYC    8   minimum clk cycles cs stays high between transactions; min 4.
// PORTS
//  clk       in   1  system clock, all logic on posedge.
//  ar        in   1  asynchronous active-low reset.
//  tx_data   in   8  byte to send.
//  tx_valid  in   1  tx_data is valid.
//  tx_last   in   1  qualifies tx_data: this is the last byte; deassert cs after it.
//  tx_ready  out  1  a byte is accepted when tx_valid & tx_ready.
//  rx_data   out  8  byte received on MISO; held until the next rx_valid.
//  rx_valid  out  1  one-clk pulse when rx_data is updated.
//  busy      out  1  high from byte acceptance until the GAP state ends.
//  sck       out  1  SPI clock, registered, idle low.
//  mosi      out  1  SPI MOSI, registered.
//  miso      in   1  SPI MISO, asynchronous; passes through a 2-flop synchronizer before use.
//  cs        out  1  SPI chip select, active low, registered.
// BEHAVIOUR
//  Reset (ar low, immediate, including mid-transfer):
//   - cs=1, sck=0, mosi=0, rx_data=0, rx_valid=0, busy=0.
//   - tx_ready=1, state=IDLE, counters=0.
//  tx_ready = (state==IDLE)|(state==WAIT); no other state accepts a byte.
//  States:
//   - IDLE: on accept, latch byte and last, drive cs=0 and mosi=tx_data[7], set busy=1, go to SETUP.
//   - SETUP: hold SETUP_CYC clks, sck=0, then go to LOW.
//   - LOW: sck=0 for HALF_DIV clks. On the final clk, set sck<=1 and sample synced MISO into the shift register LSB; go to HIGH.
//   - HIGH: sck=1 for HALF_DIV clks. On the final clk, set sck<=0.
//     - bits 0..6: shift MOSI to the next bit; go to LOW.
//     - bit 7: set rx_data<=shift, rx_valid<=1; go to WAIT if last=0, else to HOLD.
//   - WAIT: cs stays low, sck=0. On accept, latch byte, drive mosi=bit7, go to LOW (no SETUP). There is no timeout; the master waits indefinitely.
//   - HOLD: SETUP_CYC clks, then cs<=1; go to GAP.
//   - GAP: GAP_CYC clks, then busy<=0; go to IDLE.
//  Per-byte SCK time is exactly 16*HALF_DIV clks; consecutive bytes under one cs add only the host latency in WAIT.
//  Bit counter is 3 bits and wraps 7->0 at byte end. Half-period counter is 8 bits, loaded with HALF_DIV-1, end at 0.
//  Simultaneous accept and rx_valid: legal on the clk leaving HIGH; WAIT is entered after it, so accept is the next cycle at the earliest.
//  tx_valid while not ready is ignored and is not latched.
// CONFIGURATION
//  SPI_MASTER_XFER_CNT_EN defined:
//   - adds output xfer_cnt[7:0], reset 0.
//   - increments, wrapping 255->0, on each cs 0->1 transition.
//   - used to cross-check the slave's returned transaction count.
//  SPI_MASTER_XFER_CNT_EN undefined: port and counter are absent; the rest of the behaviour is identical.
// STRUCTURE
//  Package spi_pkg: state enum (IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP), SPI_BYTE_W=8, HALF_DIV and cycle-count bounds.
//  Sub-module spi_sync2: 2-flop synchronizer with async active-low reset to 0; instanced on miso.
// TESTING
//  - Single byte 0xA5, last=1, slave model fresh after reset:
//    - MOSI sampled at SCK rises = 1,0,1,0,0,1,0,1; rx_data=0x00; one rx_valid pulse.
//    - cs low for 2*SETUP_CYC+128 clks at defaults.
//  - 3-byte burst 0x01,0x02,0x03 (last on 0x03), second transaction after reset:
//    - cs stays low across all bytes; rx bytes = 0x01,0x00,0x00.
//    - exactly 24 SCK rises; cs high for >=GAP_CYC clks afterwards.
//  - Host stalls 50 clks in WAIT before byte 2: sck stays 0, cs stays 0, tx_ready=1; transfer then resumes correctly.
//  - ar pulsed low mid-byte (bit 4 HIGH phase): next clk cs=1, sck=0, busy=0, tx_ready=1; no rx_valid.
//    The next transaction completes normally.
//  - HALF_DIV=8 with MISO toggled 3 clks after each SCK fall: all 8 bits are sampled correctly.
//  - With SPI_MASTER_XFER_CNT_EN: 257 transactions -> xfer_cnt=1. Without it: the build has no xfer_cnt port.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

    localparam int SPI_BYTE_W     = 8;
    localparam int HALF_DIV_DEF   = 8;
    localparam int HALF_DIV_MIN   = 8;
    localparam int HALF_DIV_MAX   = 255;
    localparam int SETUP_CYC_DEF  = 6;
    localparam int SETUP_CYC_MIN  = 4;
    localparam int GAP_CYC_DEF    = 8;
    localparam int GAP_CYC_MIN    = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        WAIT,
        HOLD,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
module spi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first), multi-byte frames under one cs.
// Optional SPI_MASTER_XFER_CNT_EN adds xfer_cnt, counting completed cs frames.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV  = HALF_DIV_DEF,   // 8..255
    parameter int SETUP_CYC = SETUP_CYC_DEF,  // >= 4
    parameter int GAP_CYC   = GAP_CYC_DEF     // >= 4
) (
    input  logic                  clk,
    input  logic                  ar,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
`ifdef SPI_MASTER_XFER_CNT_EN
    ,
    output logic [7:0]            xfer_cnt
`endif
);

    localparam logic [7:0] HALF_LD  = 8'(HALF_DIV - 1);
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

    spi_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [SPI_BYTE_W-1:0] txsh_q, txsh_d;
    logic [SPI_BYTE_W-1:0] rxsh_q, rxsh_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  last_q, last_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_q, cs_d;
    logic                  busy_q, busy_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_s;
    logic                  accept;
    logic                  cnt_zero;

    spi_sync2 u_miso_sync (
        .clk   (clk),
        .rst_n (ar),
        .d_i   (miso),
        .q_o   (miso_s)
    );

    assign tx_ready = (state_q == IDLE) || (state_q == WAIT);
    assign accept   = tx_valid && tx_ready;
    assign cnt_zero = (cnt_q == 8'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    txsh_d  = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[SPI_BYTE_W-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd0;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = HALF_LD;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    sck_d   = 1'b1;
                    rxsh_d  = {rxsh_q[SPI_BYTE_W-2:0], miso_s};
                    cnt_d   = HALF_LD;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    sck_d = 1'b0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        // rxsh already holds all 8 bits: the last one was taken on this byte's final rise.
                        rx_data_d  = rxsh_q;
                        rx_valid_d = 1'b1;
                        if (last_q) begin
                            cnt_d   = SETUP_LD;
                            state_d = HOLD;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        txsh_d  = {txsh_q[SPI_BYTE_W-2:0], 1'b0};
                        mosi_d  = txsh_q[SPI_BYTE_W-2];
                        cnt_d   = HALF_LD;
                        state_d = LOW;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT: begin
                if (accept) begin
                    txsh_d  = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[SPI_BYTE_W-1];
                    cnt_d   = HALF_LD;
                    state_d = LOW;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    cs_d    = 1'b1;
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;

`ifdef SPI_MASTER_XFER_CNT_EN
    logic [7:0] xfer_cnt_q;

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            xfer_cnt_q <= 8'd0;
        end else if (!cs_q && cs_d) begin
            xfer_cnt_q <= xfer_cnt_q + 8'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a behavioural SPI slave model.
module tb_spi_master;

    localparam int HD = 8;
    localparam int SC = 6;
    localparam int GC = 8;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } slv_t;

    typedef struct {
        int n;
        bit single;
    } txn_t;

    logic       clk = 1'b0;
    logic       ar  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck;
    logic       mosi;
    logic       miso = 1'b0;
    logic       cs;
`ifdef SPI_MASTER_XFER_CNT_EN
    logic [7:0] xfer_cnt;
`endif

    int         errors = 0;
    int         checks = 0;
    slv_t       slv_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_mosi_q[$];
    txn_t       exp_txn_q[$];
    logic [7:0] txb[8];
    logic [7:0] rxb[8];

    always #5 clk = ~clk;

    spi_master #(.HALF_DIV(HD), .SETUP_CYC(SC), .GAP_CYC(GC)) dut (
        .clk      (clk),
        .ar       (ar),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .cs       (cs)
`ifdef SPI_MASTER_XFER_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Slave: first bit appears after cs falls, later bits ~3 clks after each SCK fall.
    initial begin : slave
        slv_t cur;
        int   nbit = 7;
        int   dly  = 0;
        bit   act  = 0;
        bit   pcs  = 1;
        bit   psck = 0;
        cur.b = 8'h00;
        cur.last = 1'b1;
        forever begin
            @(negedge clk);
            if (!ar) begin
                act = 0; dly = 0; pcs = 1; psck = 0;
                slv_q.delete();
            end else begin
                if (pcs && !cs) begin
                    if (slv_q.size() > 0) begin
                        cur = slv_q.pop_front(); act = 1; nbit = 7; dly = 4;
                    end
                end else if (act && psck && !sck) begin
                    nbit--;
                    if (nbit < 0) begin
                        if (cur.last || slv_q.size() == 0) act = 0;
                        else begin cur = slv_q.pop_front(); nbit = 7; end
                    end
                    if (act) dly = 4;
                end
                if (!pcs && cs) act = 0;
                if (act && dly > 0) begin
                    dly--;
                    if (dly == 0) miso = cur.b[nbit];
                end
                pcs = cs;
                psck = sck;
            end
        end
    end

    // Monitor: rx bytes, MOSI bytes at SCK rises, frame shape of each cs window.
    initial begin : monitor
        bit         pcs = 1;
        bit         psck = 0;
        bit         seen = 0;
        int         nb = 0, rises = 0, lowc = 0, highc = 0;
        logic [7:0] msh = 8'h00;
        txn_t       t;
        forever begin
            @(negedge clk);
            if (!ar) begin
                pcs = 1; psck = 0; nb = 0; rises = 0; lowc = 0; highc = 0; seen = 0;
            end else begin
                if (rx_valid) begin
                    if (exp_rx_q.size() == 0) chk("rx_unexpected", rx_valid, 1'b0);
                    else chk("rx_data", rx_data, exp_rx_q.pop_front());
                end
                if (sck && !psck) begin
                    msh = {msh[6:0], mosi};
                    nb++;
                    rises++;
                    if (nb == 8) begin
                        nb = 0;
                        if (exp_mosi_q.size() == 0) fail_now("mosi_unexpected_byte");
                        else chk("mosi_byte", msh, exp_mosi_q.pop_front());
                    end
                end
                if (pcs && !cs) begin
                    if (seen) begin
                        checks++;
                        if (highc < GC) begin
                            errors++;
                            $display("FAIL cs_gap: got %0d expected >= %0d", highc, GC);
                        end
                    end
                    lowc = 0;
                end
                if (!pcs && cs) begin
                    if (exp_txn_q.size() == 0) fail_now("cs_frame_unexpected");
                    else begin
                        t = exp_txn_q.pop_front();
                        chk("sck_rises", rises, 8 * t.n);
                        if (t.single) chk("cs_low_len", lowc, 2 * SC + 16 * HD);
                    end
                    rises = 0; nb = 0; highc = 0; seen = 1;
                end
                if (!cs) lowc++;
                else highc++;
                pcs = cs;
                psck = sck;
            end
        end
    end

    task automatic put_byte(input logic [7:0] b, input bit last);
        int t = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        forever begin
            if (tx_ready) begin
                tx_data = b;
                tx_last = last;
                @(posedge clk);
                break;
            end
            // Junk on the bus while not ready must never be latched.
            tx_data = 8'($urandom);
            tx_last = 1'($urandom);
            @(negedge clk);
            t++;
            if (t > 5000) begin
                fail_now("tx_ready_timeout");
                break;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail_now("busy_timeout");
    endtask

    task automatic send_txn(input int n, input int stall);
        int t;
        exp_txn_q.push_back('{n: n, single: (n == 1)});
        for (int i = 0; i < n; i++) begin
            slv_q.push_back('{b: rxb[i], last: (i == n - 1)});
            exp_rx_q.push_back(rxb[i]);
            exp_mosi_q.push_back(txb[i]);
        end
        for (int i = 0; i < n; i++) begin
            if (i == 1 && stall > 0) begin
                t = 0;
                while (!tx_ready && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                repeat (stall) begin
                    @(negedge clk);
                    chk("stall_sck", sck, 1'b0);
                    chk("stall_cs", cs, 1'b0);
                    chk("stall_ready", tx_ready, 1'b1);
                end
            end else if (i > 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            put_byte(txb[i], i == n - 1);
        end
        wait_idle();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 ar = 1'b0;
        repeat (3) @(negedge clk);
        #2 ar = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r, t, rvc, n;
        bit ps;

        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
`ifdef SPI_MASTER_XFER_CNT_EN
        chk("rst_xfer_cnt", xfer_cnt, 8'h00);
`endif
        #2 ar = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, slave returns 0x00.
        txb[0] = 8'hA5; rxb[0] = 8'h00;
        send_txn(1, 0);

        // Three-byte burst, slave returns its transaction count then zeros.
        txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h03;
        rxb[0] = 8'h01; rxb[1] = 8'h00; rxb[2] = 8'h00;
        send_txn(3, 0);

        // Host stalls 50 clks in WAIT before byte 2.
        for (int i = 0; i < 2; i++) begin txb[i] = 8'($urandom); rxb[i] = 8'($urandom); end
        send_txn(2, 50);

        // Abort during the HIGH phase of bit 4.
        slv_q.push_back('{b: 8'h5A, last: 1'b1});
        put_byte(8'($urandom), 1'b1);
        r = 0; t = 0; ps = sck;
        while (r < 5 && t < 3000) begin
            @(negedge clk);
            if (sck && !ps) r++;
            ps = sck;
            t++;
        end
        if (r < 5) fail_now("abort_sck_timeout");
        repeat (3) @(negedge clk);
        #2 ar = 1'b0;
        #1;
        chk("abort_cs", cs, 1'b1);
        chk("abort_sck", sck, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_tx_ready", tx_ready, 1'b1);
        chk("abort_rx_valid", rx_valid, 1'b0);
        repeat (3) @(negedge clk);
        #2 ar = 1'b1;
        rvc = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_valid) rvc++;
        end
        chk("abort_no_rx", rvc, 0);
        txb[0] = 8'($urandom); rxb[0] = 8'($urandom);
        send_txn(1, 0);

        // Randomized frames.
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin txb[i] = 8'($urandom); rxb[i] = 8'($urandom); end
            send_txn(n, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);
        end

`ifdef SPI_MASTER_XFER_CNT_EN
        pulse_reset();
        chk("xfer_cnt_after_reset", xfer_cnt, 8'h00);
        for (int k = 0; k < 257; k++) begin
            txb[0] = 8'($urandom); rxb[0] = 8'($urandom);
            send_txn(1, 0);
        end
        chk("xfer_cnt_wrap", xfer_cnt, 8'h01);
`else
        pulse_reset();
`endif

        repeat (5) @(negedge clk);
        chk("rx_queue_drained", exp_rx_q.size(), 0);
        chk("mosi_queue_drained", exp_mosi_q.size(), 0);
        chk("txn_queue_drained", exp_txn_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
